hq2x_line_reader: RTL and testbench
===================================

// Module: hq2x_line_reader
// PURPOSE
//  Read-side controller for the hq2x ping-pong input line buffers. When the write side reports a
//  completed line, this block drives rdbuf/rdaddr to stream that line out twice (scan-doubled
//  output), re-registering RAM data into a pixel stream with valid and line-marker strobes.
//  It sits between the two-bank line buffer and the hq2x filter/output stage.
// PARAMETERS
//  LENGTH  256  max pixels per line; must match the buffer instance
//  DWIDTH  23   MSB index of pixel word (data is DWIDTH+1 bits)
//  AWIDTH  (localparam) MSB index of address, same LENGTH ladder as the buffer (256 -> 7)
// PORTS
//  clk         in   1          system clock
//  reset       in   1          synchronous, active-high reset
//  ce_out      in   1          output pixel enable; all advance only when high
//  line_ready  in   1          1-cycle pulse: a complete line sits in bank line_buf
//  line_buf    in   1          bank holding the completed line (sampled with line_ready)
//  line_len    in   AWIDTH+2   pixel count of that line (sampled with line_ready)
//  rdbuf       out  1          bank select to buffer
//  rdaddr      out  AWIDTH+1   read address to buffer
//  q           in   DWIDTH+1   buffer read data, valid 1 clk after rdaddr
//  pix_out     out  DWIDTH+1   output pixel
//  pix_valid   out  1          pix_out valid this cycle
//  line_first  out  1          high with first pixel of each output line
//  pass        out  1          0 = first copy, 1 = repeat copy (held during pix_valid)
//  busy        out  1          a line is being read
//  overrun     out  1          1-cycle pulse: pending line overwritten before use
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; pending slot empty; overrides any activity mid-line.
//  Length: len = min(line_len, LENGTH); line_ready with len==0 ignored entirely.
//  FSM states: IDLE, PASS0, PASS1.
//   IDLE: on accepted line_ready -> latch buf/len, rdbuf<=buf, rdaddr<=0, busy<=1, -> PASS0.
//   PASS0/PASS1: on each ce_out cycle issue rdaddr, then rdaddr++; when issued addr==len-1 the
//    pass ends: PASS0 -> PASS1 (rdaddr<=0, same bank); PASS1 -> PASS0 of pending line if
//    pending, else IDLE (busy<=0 after final pixel's pix_valid).
//   ce_out low: rdaddr, FSM and counters hold; no new pix_valid issued.
//  Pipeline: pix_valid/pix_out/line_first/pass registered, exactly 1 clk after the ce_out cycle
//   that issued the address (pix_out <= q on the cycle after issue). pix_valid is 1-clk pulse.
//   pix_out holds last value when pix_valid low.
//  line_first: asserted with the pixel read from address 0 of each pass.
//  Pending: line_ready while busy stores buf/len in a single pending slot.
//   Slot already full -> new values overwrite, overrun pulses 1 clk.
//   line_ready in same cycle PASS1 ends with empty slot -> go straight to PASS0 of new line,
//   no idle cycle; with full slot -> start slot line, store new one, overrun pulses.
//   line_ready naming the bank currently being read is accepted as-is (writer's responsibility).
//  Back-to-back: with ce_out held high, a len-pixel line yields 2*len consecutive pix_valid
//   cycles; next line's first pixel follows with no bubble.
// TESTING
//  T1 reset, line_ready buf=1 len=4, ce_out=1 -> rdbuf=1, rdaddr 0,1,2,3,0,1,2,3; 8 pix_valid,
//     pix_out = bank1[0..3] twice; line_first on 1st and 5th; pass 0x4 then 1x4; busy low after.
//  T2 same with ce_out high every 3rd clk -> identical pixel sequence, pix_valid 1 clk after each
//     ce_out cycle, rdaddr stable between enables.
//  T3 line A (buf0,len 3) then line B (buf1,len 2) pulsed mid PASS0 -> 6 pixels of A then 4 of B,
//     no gap, overrun never set.
//  T4 during A pulse B then C before A ends -> overrun 1 clk at C; output A,A then C,C; B dropped.
//  T5 line_len=0 -> no state change; line_len=300 (LENGTH 256) -> 512 pixels, addresses 0..255.
//  T6 assert reset at 2nd pixel of PASS1 -> next clk all outputs 0, IDLE, pending cleared.

Source files
------------

// File: rtl/hq2x_line_reader.sv
// Purpose : read-side controller for the hq2x ping-pong line buffers. Each completed line
//           is streamed out twice (pass 0, then pass 1) as a registered pixel stream.
// Latency : the address is sampled by the buffer on the ce_out edge that issues it. pix_out,
//           pix_valid, line_first and pass are all registered together on the following edge.
// Backpr. : ce_out low freezes rdaddr, the FSM and the counters. One extra line can be queued
//           in a pending slot. A further line_ready overwrites that slot and pulses overrun.
// Ports   : clk/reset (sync, active high); ce_out pixel enable; line_ready/line_buf/line_len
//           from the writer; rdbuf/rdaddr/q to the buffer; pix_out/pix_valid/line_first/pass
//           to the filter; busy and overrun status.
module hq2x_line_reader #(
  parameter int LENGTH = 256,
  parameter int DWIDTH = 23,
  localparam int AWIDTH = $clog2(LENGTH) - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_out,
  input  logic              line_ready,
  input  logic              line_buf,
  input  logic [AWIDTH+1:0] line_len,
  output logic              rdbuf,
  output logic [AWIDTH:0]   rdaddr,
  input  logic [DWIDTH:0]   q,
  output logic [DWIDTH:0]   pix_out,
  output logic              pix_valid,
  output logic              line_first,
  output logic              pass,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_t;

  localparam logic [AWIDTH+1:0] LEN_MAX = (AWIDTH+2)'(LENGTH);
  localparam logic [AWIDTH+1:0] LEN_ONE = (AWIDTH+2)'(1);
  localparam logic [AWIDTH:0]   ADR_ONE = (AWIDTH+1)'(1);

  state_t              state_q, state_d;
  logic                rdbuf_q, rdbuf_d;
  logic [AWIDTH:0]     rdaddr_q, rdaddr_d;
  logic [AWIDTH+1:0]   cur_len_q, cur_len_d;
  logic                pend_vld_q, pend_vld_d;
  logic                pend_buf_q, pend_buf_d;
  logic [AWIDTH+1:0]   pend_len_q, pend_len_d;
  logic                overrun_q, overrun_d;
  logic                busy_q;
  // First pipeline stage: describes the address the buffer is reading this cycle.
  logic                s1_vld_q, s1_first_q, s1_pass_q;
  // Second stage: the outputs themselves.
  logic [DWIDTH:0]     pix_out_q;
  logic                pix_valid_q, line_first_q, pass_q;

  logic              accept, issue, last;
  logic [AWIDTH+1:0] len_in, len_m1;

  // Over-long lines are clipped to the buffer depth; zero-length lines never start anything.
  assign len_in = (line_len > LEN_MAX) ? LEN_MAX : line_len;
  assign accept = line_ready && (line_len != '0);
  assign issue  = ce_out && (state_q != IDLE);
  assign len_m1 = cur_len_q - LEN_ONE;
  assign last   = issue && (rdaddr_q == len_m1[AWIDTH:0]);

  always_comb begin
    state_d    = state_q;
    rdbuf_d    = rdbuf_q;
    rdaddr_d   = rdaddr_q;
    cur_len_d  = cur_len_q;
    pend_vld_d = pend_vld_q;
    pend_buf_d = pend_buf_q;
    pend_len_d = pend_len_q;
    overrun_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = PASS0;
          rdbuf_d   = line_buf;
          cur_len_d = len_in;
          rdaddr_d  = '0;
        end
      end
      PASS0: begin
        if (issue) rdaddr_d = last ? '0 : rdaddr_q + ADR_ONE;
        if (last) state_d = PASS1;
        if (accept) begin
          pend_vld_d = 1'b1;
          pend_buf_d = line_buf;
          pend_len_d = len_in;
          overrun_d  = pend_vld_q;
        end
      end
      PASS1: begin
        if (last) begin
          rdaddr_d = '0;
          if (pend_vld_q) begin
            // Queued line starts at once; a simultaneous new line takes its slot and
            // is flagged, since the writer has produced lines faster than they drain.
            state_d    = PASS0;
            rdbuf_d    = pend_buf_q;
            cur_len_d  = pend_len_q;
            pend_vld_d = accept;
            pend_buf_d = line_buf;
            pend_len_d = len_in;
            overrun_d  = accept;
          end else if (accept) begin
            state_d   = PASS0;
            rdbuf_d   = line_buf;
            cur_len_d = len_in;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (issue) rdaddr_d = rdaddr_q + ADR_ONE;
          if (accept) begin
            pend_vld_d = 1'b1;
            pend_buf_d = line_buf;
            pend_len_d = len_in;
            overrun_d  = pend_vld_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rdbuf_q      <= 1'b0;
      rdaddr_q     <= '0;
      cur_len_q    <= '0;
      pend_vld_q   <= 1'b0;
      pend_buf_q   <= 1'b0;
      pend_len_q   <= '0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_pass_q    <= 1'b0;
      pix_out_q    <= '0;
      pix_valid_q  <= 1'b0;
      line_first_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdbuf_q      <= rdbuf_d;
      rdaddr_q     <= rdaddr_d;
      cur_len_q    <= cur_len_d;
      pend_vld_q   <= pend_vld_d;
      pend_buf_q   <= pend_buf_d;
      pend_len_q   <= pend_len_d;
      overrun_q    <= overrun_d;
      // Busy covers the reads still in the pipeline so it drops only after the last pixel.
      busy_q       <= (state_d != IDLE) || issue || s1_vld_q;
      s1_vld_q     <= issue;
      s1_first_q   <= issue && (rdaddr_q == '0);
      s1_pass_q    <= (state_q == PASS1);
      pix_valid_q  <= s1_vld_q;
      line_first_q <= s1_vld_q && s1_first_q;
      if (s1_vld_q) begin
        pix_out_q <= q;
        pass_q    <= s1_pass_q;
      end
    end
  end

  assign rdbuf      = rdbuf_q;
  assign rdaddr     = rdaddr_q;
  assign pix_out    = pix_out_q;
  assign pix_valid  = pix_valid_q;
  assign line_first = line_first_q;
  assign pass       = pass_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_hq2x_line_reader.sv
module tb_hq2x_line_reader;

  logic        clk = 1'b0;
  logic        reset, ce_out, line_ready, line_buf;
  logic [8:0]  line_len;
  logic        rdbuf;
  logic [7:0]  rdaddr;
  logic [23:0] q;
  logic [23:0] pix_out;
  logic        pix_valid, line_first, pass, busy, overrun;

  hq2x_line_reader #(.LENGTH(256), .DWIDTH(23)) dut (
    .clk(clk), .reset(reset), .ce_out(ce_out), .line_ready(line_ready),
    .line_buf(line_buf), .line_len(line_len), .rdbuf(rdbuf), .rdaddr(rdaddr),
    .q(q), .pix_out(pix_out), .pix_valid(pix_valid), .line_first(line_first),
    .pass(pass), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] pix;
    logic        first;
    logic        pas;
  } px_t;

  int   passes = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   ov_cnt = 0;
  px_t  got[$];
  px_t  exp_q[$];
  int   got_cyc[$];

  function automatic logic [23:0] pixv(input logic b, input int a);
    logic [7:0] a8;
    a8 = a[7:0];
    return {4'hA, 3'b000, b, 8'h5C, a8};
  endfunction

  // Two-bank buffer with registered read: q follows the address one clock later.
  logic [23:0] mem0 [256];
  logic [23:0] mem1 [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = pixv(1'b0, i);
      mem1[i] = pixv(1'b1, i);
    end
  end
  always @(posedge clk) q <= rdbuf ? mem1[rdaddr] : mem0[rdaddr];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_valid) begin
      px_t e;
      e.pix = pix_out; e.first = line_first; e.pas = pass;
      got.push_back(e);
      got_cyc.push_back(cyc);
    end
    if (overrun) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic pulse(input logic b, input int len);
    line_ready = 1'b1; line_buf = b; line_len = 9'(len);
    @(negedge clk);
    line_ready = 1'b0;
  endtask

  task automatic add_line(input logic b, input int len);
    px_t e;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < len; a++) begin
        e.pix = pixv(b, a); e.first = (a == 0); e.pas = p[0];
        exp_q.push_back(e);
      end
  endtask

  task automatic wait_idle(input string tag, input int max);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < max) begin
      @(negedge clk);
      n++;
      if (!busy && !pix_valid) quiet++; else quiet = 0;
    end
    chk({tag, "_idle"}, (quiet >= 3) ? 64'd1 : 64'd0, 64'd1);
  endtask

  task automatic clear_q();
    got.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_px%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    if (got.size() > 0)
      chk({tag, "_nogap"}, 64'(got_cyc[got.size()-1] - got_cyc[0]), 64'(got.size() - 1));
    clear_q();
  endtask

  initial begin
    int a_keep;
    reset = 1'b1; ce_out = 1'b0; line_ready = 1'b0; line_buf = 1'b0; line_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_pix_valid", 64'(pix_valid), 0);
    chk("rst_pix_out", 64'(pix_out), 0);
    chk("rst_line_first", 64'(line_first), 0);
    chk("rst_pass", 64'(pass), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_overrun", 64'(overrun), 0);
    chk("rst_rdaddr", 64'(rdaddr), 0);
    chk("rst_rdbuf", 64'(rdbuf), 0);
    reset = 1'b0;
    @(negedge clk);

    // T1: bank 1, four pixels, ce_out always high
    ce_out = 1'b1;
    pulse(1'b1, 4);
    chk("t1_rdbuf", 64'(rdbuf), 1);
    chk("t1_busy", 64'(busy), 1);
    wait_idle("t1", 100);
    add_line(1'b1, 4);
    cmp_stream("t1");
    chk("t1_busy_end", 64'(busy), 0);

    // T2: ce_out every third clock
    ce_out = 1'b0;
    pulse(1'b1, 4);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_quiet%0d", k), 64'(pix_valid), 0);
      ce_out = 1'b1;
      @(negedge clk);
      ce_out = 1'b0;
      a_keep = int'(rdaddr);
      chk($sformatf("t2_addr%0d", k), 64'(rdaddr), 64'((k + 1) % 4));
      chk($sformatf("t2_early%0d", k), 64'(pix_valid), 0);
      @(negedge clk);
      chk($sformatf("t2_hold%0d", k), 64'(rdaddr), 64'(a_keep));
      chk($sformatf("t2_vld%0d", k), 64'(pix_valid), 1);
      chk($sformatf("t2_pix%0d", k), 64'(pix_out), 64'(pixv(1'b1, k % 4)));
      chk($sformatf("t2_first%0d", k), 64'(line_first), 64'((k % 4) == 0));
      chk($sformatf("t2_pass%0d", k), 64'(pass), 64'(k / 4));
      @(negedge clk);
    end
    wait_idle("t2", 50);
    clear_q();

    // T3: second line queued during PASS0, then a line arriving on the final PASS1 read
    ce_out = 1'b1;
    ov_cnt = 0;
    pulse(1'b0, 3);
    pulse(1'b1, 2);
    wait_idle("t3", 100);
    add_line(1'b0, 3);
    add_line(1'b1, 2);
    cmp_stream("t3");
    pulse(1'b1, 2);
    repeat (3) @(negedge clk);
    pulse(1'b0, 3);
    wait_idle("t3b", 100);
    add_line(1'b1, 2);
    add_line(1'b0, 3);
    cmp_stream("t3b");
    chk("t3_no_overrun", 64'(ov_cnt), 0);

    // T4: B then C queued while A runs; C overwrites B
    pulse(1'b0, 3);
    pulse(1'b1, 2);
    chk("t4_no_ov_b", 64'(overrun), 0);
    pulse(1'b0, 4);
    chk("t4_ov_at_c", 64'(overrun), 1);
    wait_idle("t4", 100);
    chk("t4_ov_count", 64'(ov_cnt), 1);
    add_line(1'b0, 3);
    add_line(1'b0, 4);
    cmp_stream("t4");

    // T5: zero length ignored; over-long line clipped to 256
    pulse(1'b1, 0);
    chk("t5_zero_busy", 64'(busy), 0);
    repeat (3) @(negedge clk);
    chk("t5_zero_none", 64'(got.size()), 0);
    pulse(1'b1, 300);
    wait_idle("t5", 700);
    add_line(1'b1, 256);
    cmp_stream("t5");

    // T6: reset at second read of PASS1 with a line pending
    pulse(1'b0, 4);
    pulse(1'b1, 3);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_pix_valid", 64'(pix_valid), 0);
    chk("t6_pix_out", 64'(pix_out), 0);
    chk("t6_line_first", 64'(line_first), 0);
    chk("t6_pass", 64'(pass), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_rdaddr", 64'(rdaddr), 0);
    chk("t6_rdbuf", 64'(rdbuf), 0);
    reset = 1'b0;
    clear_q();
    repeat (20) @(negedge clk);
    chk("t6_pending_gone", 64'(got.size()), 0);
    chk("t6_busy_after", 64'(busy), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
